// File: rtl/core_ldalign_pkg.sv
// Shared types and helpers for the load-data alignment unit.
package core_ldalign_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ0,
      S_WAIT0,
      S_REQ1,
      S_WAIT1,
      S_RESP
   } ldalign_state_e;

   typedef enum logic [1:0] {
      LD_B = 2'b00,
      LD_H = 2'b01,
      LD_W = 2'b10,
      LD_D = 2'b11
   } ld_size_e;

   // Number of bytes covered by a load of the given size code.
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/core_ldext_unit.sv
// Sign/zero extension of an already right-justified load value.
module core_ldext_unit
   import core_ldalign_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] data_i,
   input  logic [1:0]      size_i,
   input  logic            su_extend_i,
   output logic [XLEN-1:0] ext_o
);

   logic [XLEN-1:0] mask;
   logic            sbit;

   // Keep the addressed bytes and fill the rest with the sign bit or zeros.
   always_comb begin
      mask = '1;
      sbit = 1'b0;
      case (size_i)
         LD_B: begin
            mask = XLEN'(8'hFF);
            sbit = data_i[7];
         end
         LD_H: begin
            mask = XLEN'(16'hFFFF);
            sbit = data_i[15];
         end
         LD_W: begin
            mask = XLEN'(32'hFFFF_FFFF);
            sbit = data_i[31];
         end
         default: begin
            mask = '1;
            sbit = 1'b0;
         end
      endcase
      ext_o = (data_i & mask) | ((!su_extend_i && sbit) ? ~mask : '0);
   end

endmodule

// File: rtl/core_ldalign.sv
// Load-data unit: issues one or two aligned beats per load, merges,
// right-justifies and extends the addressed bytes.
module core_ldalign
   import core_ldalign_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int AW          = 64,
   parameter bit MISALIGN_EN = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic [AW-1:0]   i_req_addr,
   input  logic [1:0]      i_req_size,
   input  logic            i_req_su_extend,
   output logic            o_mem_valid,
   input  logic            i_mem_ready,
   output logic [AW-1:0]   o_mem_addr,
   input  logic            i_mem_rvalid,
   input  logic [XLEN-1:0] i_mem_rdata,
   input  logic            i_mem_err,
   output logic            o_rsp_valid,
   input  logic            i_rsp_ready,
   output logic [XLEN-1:0] o_rsp_rdata,
   output logic            o_rsp_err
);

   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   ldalign_state_e  state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [1:0]      size_q, size_d;
   logic            su_q, su_d;
   logic [XLEN-1:0] buf0_q, buf0_d;
   logic [XLEN-1:0] buf1_q, buf1_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            err_q, err_d;

   logic [OW-1:0]     off_in, off_q;
   logic              cross_in, cross_q, illegal_in;
   logic [AW-1:0]     aligned;
   logic [2*XLEN-1:0] merged;
   logic [XLEN-1:0]   ext_data;

   assign off_in     = i_req_addr[OW-1:0];
   assign off_q      = addr_q[OW-1:0];
   assign cross_in   = (5'(off_in) + 5'(size_bytes(i_req_size))) > 5'(NB);
   assign cross_q    = (5'(off_q) + 5'(size_bytes(size_q))) > 5'(NB);
   assign illegal_in = ((i_req_size == LD_D) && (XLEN == 32)) ||
                       (cross_in && !MISALIGN_EN);
   assign aligned    = {addr_q[AW-1:OW], {OW{1'b0}}};

   // Beat buffers: cleared on a new request, filled as each beat returns.
   always_comb begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      if (state_q == S_IDLE && i_req_valid) begin
         buf0_d = '0;
         buf1_d = '0;
      end
      if (state_q == S_WAIT0 && i_mem_rvalid) buf0_d = i_mem_rdata;
      if (state_q == S_WAIT1 && i_mem_rvalid) buf1_d = i_mem_rdata;
   end

   // Merge uses the incoming beat so the result can be registered on RESP entry.
   assign merged = {buf1_d, buf0_d} >> {off_q, 3'b000};

   core_ldext_unit #(.XLEN(XLEN)) u_ext (
      .data_i      (merged[XLEN-1:0]),
      .size_i      (size_q),
      .su_extend_i (su_q),
      .ext_o       (ext_data)
   );

   // Next-state, handshake outputs and result capture.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      size_d      = size_q;
      su_d        = su_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      o_req_ready = 1'b0;
      o_mem_valid = 1'b0;
      o_rsp_valid = 1'b0;
      o_mem_addr  = '0;
      case (state_q)
         S_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               addr_d = i_req_addr;
               size_d = i_req_size;
               su_d   = i_req_su_extend;
               if (illegal_in) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = S_REQ0;
                  err_d   = 1'b0;
               end
            end
         end
         S_REQ0: begin
            o_mem_valid = 1'b1;
            o_mem_addr  = aligned;
            if (i_mem_ready) state_d = S_WAIT0;
         end
         S_WAIT0: begin
            if (i_mem_rvalid) begin
               if (i_mem_err) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else if (cross_q) begin
                  state_d = S_REQ1;
               end else begin
                  state_d = S_RESP;
                  err_d   = 1'b0;
                  rdata_d = ext_data;
               end
            end
         end
         S_REQ1: begin
            o_mem_valid = 1'b1;
            o_mem_addr  = aligned + AW'(NB);
            if (i_mem_ready) state_d = S_WAIT1;
         end
         S_WAIT1: begin
            if (i_mem_rvalid) begin
               state_d = S_RESP;
               err_d   = i_mem_err;
               rdata_d = i_mem_err ? '0 : ext_data;
            end
         end
         S_RESP: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         su_q    <= 1'b0;
         buf0_q  <= '0;
         buf1_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         su_q    <= su_d;
         buf0_q  <= buf0_d;
         buf1_q  <= buf1_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign o_rsp_rdata = rdata_q;
   assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_core_ldalign.sv
// Directed bench for core_ldalign (XLEN=64), plus a MISALIGN_EN=0 instance.
module tb_core_ldalign;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid, req_ready, req_su;
   logic [63:0] req_addr;
   logic [1:0]  req_size;
   logic        mem_valid, mem_ready, mem_rvalid, mem_err;
   logic [63:0] mem_addr, mem_rdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [63:0] rsp_rdata;

   logic        b_req_valid, b_req_ready, b_req_su;
   logic [63:0] b_req_addr;
   logic [1:0]  b_req_size;
   logic        b_mem_valid, b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [63:0] b_mem_addr, b_rsp_rdata;

   int n_checks = 0;
   int n_pass   = 0;
   int mem_hs   = 0;
   int b_mem_seen = 0;

   always #5 clk = ~clk;

   core_ldalign #(.XLEN(64), .AW(64), .MISALIGN_EN(1'b1)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
      .i_req_size(req_size), .i_req_su_extend(req_su),
      .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
      .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .i_mem_err(mem_err),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
      .o_rsp_err(rsp_err)
   );

   core_ldalign #(.XLEN(64), .AW(64), .MISALIGN_EN(1'b0)) dut_nomis (
      .i_clk(clk), .i_rstn(rstn),
      .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_addr(b_req_addr),
      .i_req_size(b_req_size), .i_req_su_extend(b_req_su),
      .o_mem_valid(b_mem_valid), .i_mem_ready(1'b1), .o_mem_addr(b_mem_addr),
      .i_mem_rvalid(1'b0), .i_mem_rdata(64'h0), .i_mem_err(1'b0),
      .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready), .o_rsp_rdata(b_rsp_rdata),
      .o_rsp_err(b_rsp_err)
   );

   always @(posedge clk) begin
      if (mem_valid && mem_ready) mem_hs <= mem_hs + 1;
      if (b_mem_valid) b_mem_seen <= b_mem_seen + 1;
   end

   task automatic step();
      @(negedge clk);
   endtask

   // One-cycle request handshake (unit is idle when called).
   task automatic send_req(input logic [63:0] addr, input logic [1:0] size, input logic su);
      req_valid = 1'b1; req_addr = addr; req_size = size; req_su = su;
      step();
      req_valid = 1'b0;
   endtask

   // Serve one memory beat; ok=0 if o_mem_valid never appeared.
   task automatic mem_beat(input logic [63:0] data, input logic err,
                           output logic [63:0] addr_seen, output logic ok);
      ok = 1'b0;
      addr_seen = '0;
      for (int i = 0; i < 20; i++) begin
         if (mem_valid) begin ok = 1'b1; break; end
         step();
      end
      if (ok) begin
         addr_seen = mem_addr;
         mem_ready = 1'b1;
         step();
         mem_ready = 1'b0;
         mem_rvalid = 1'b1; mem_rdata = data; mem_err = err;
         step();
         mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      end
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) step();
      n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b want=1", req_ready); else n_pass++;
      n_checks++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid got=%b want=0", mem_valid); else n_pass++;
      n_checks++; if (mem_addr !== 64'h0) $display("FAIL reset_mem_addr got=%h want=0", mem_addr); else n_pass++;
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); else n_pass++;
      n_checks++; if (rsp_rdata !== 64'h0 || rsp_err !== 1'b0)
         $display("FAIL reset_rsp got=%h/%b want=0/0", rsp_rdata, rsp_err); else n_pass++;
      rstn = 1'b1;
      step();
      $display("txn reset done");
   endtask

   task automatic test_byte_signed();
      logic [63:0] a; logic ok; int hs0;
      hs0 = mem_hs;
      send_req(64'h1003, 2'b00, 1'b0);
      n_checks++; if (mem_valid !== 1'b1) $display("FAIL byte_mem_valid_cycle1 got=%b want=1", mem_valid); else n_pass++;
      mem_beat(64'h00000000_80000000, 1'b0, a, ok);
      n_checks++; if (!ok || a !== 64'h1000) $display("FAIL byte_beat_addr got=%h ok=%b want=1000", a, ok); else n_pass++;
      n_checks++; if (rsp_valid !== 1'b1) $display("FAIL byte_rsp_latency got=%b want=1", rsp_valid); else n_pass++;
      n_checks++; if (rsp_rdata !== 64'hFFFFFFFF_FFFFFF80 || rsp_err !== 1'b0)
         $display("FAIL byte_rdata got=%h/%b want=ffffffffffffff80/0", rsp_rdata, rsp_err); else n_pass++;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL byte_busy_ready got=%b want=0", req_ready); else n_pass++;
      consume();
      n_checks++; if (req_ready !== 1'b1 || mem_hs - hs0 !== 1)
         $display("FAIL byte_idle_hs got ready=%b hs=%0d want 1/1", req_ready, mem_hs - hs0); else n_pass++;
      $display("txn byte_signed addr=1003 rdata=%h", rsp_rdata);
   endtask

   task automatic test_half_zext();
      logic [63:0] a; logic ok;
      send_req(64'h1006, 2'b01, 1'b1);
      mem_beat(64'hBEEF0000_00000000, 1'b0, a, ok);
      n_checks++; if (!ok || rsp_valid !== 1'b1 || rsp_rdata !== 64'h0000_0000_0000_BEEF)
         $display("FAIL half_zext got=%h valid=%b want=000000000000beef", rsp_rdata, rsp_valid); else n_pass++;
      consume();
      $display("txn half_zext addr=1006 rdata=%h", rsp_rdata);
   endtask

   task automatic test_word_cross();
      logic [63:0] a0, a1; logic ok0, ok1; int hs0;
      hs0 = mem_hs;
      send_req(64'h1006, 2'b10, 1'b0);
      mem_beat(64'h3412_0000_0000_0000, 1'b0, a0, ok0);
      mem_beat(64'h0000_0000_0000_89AB, 1'b0, a1, ok1);
      n_checks++; if (!ok0 || !ok1 || a0 !== 64'h1000 || a1 !== 64'h1008)
         $display("FAIL cross_addrs got=%h,%h want=1000,1008", a0, a1); else n_pass++;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hFFFFFFFF_89AB3412 || rsp_err !== 1'b0)
         $display("FAIL cross_rdata got=%h/%b want=ffffffff89ab3412/0", rsp_rdata, rsp_err); else n_pass++;
      n_checks++; if (mem_hs - hs0 !== 2) $display("FAIL cross_hs got=%0d want=2", mem_hs - hs0); else n_pass++;
      consume();
      $display("txn word_cross addr=1006 rdata=%h", rsp_rdata);
   endtask

   task automatic test_cross_err();
      logic [63:0] a; logic ok; int hs0;
      hs0 = mem_hs;
      send_req(64'h1006, 2'b10, 1'b0);
      mem_beat(64'h3412_0000_0000_0000, 1'b1, a, ok);
      repeat (3) step();
      n_checks++; if (!ok || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 64'h0)
         $display("FAIL cross_err got=%h/%b valid=%b want=0/1/1", rsp_rdata, rsp_err, rsp_valid); else n_pass++;
      n_checks++; if (mem_hs - hs0 !== 1) $display("FAIL cross_err_hs got=%0d want=1", mem_hs - hs0); else n_pass++;
      consume();
      $display("txn cross_err addr=1006 err=%b", rsp_err);
   endtask

   task automatic test_backpressure();
      logic [63:0] a; logic ok;
      send_req(64'h2000, 2'b11, 1'b1);
      for (int i = 0; i < 2; i++) begin
         n_checks++; if (mem_valid !== 1'b1 || mem_addr !== 64'h2000)
            $display("FAIL bp_mem_hold%0d got=%b/%h want=1/2000", i, mem_valid, mem_addr); else n_pass++;
         step();
      end
      mem_beat(64'h01234567_89ABCDEF, 1'b0, a, ok);
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (!ok || rsp_valid !== 1'b1 || rsp_rdata !== 64'h01234567_89ABCDEF || req_ready !== 1'b0)
            $display("FAIL bp_rsp_hold%0d got=%b/%h ready=%b want=1/0123456789abcdef/0",
                     i, rsp_valid, rsp_rdata, req_ready); else n_pass++;
         step();
      end
      consume();
      $display("txn backpressure addr=2000 rdata=%h", rsp_rdata);
   endtask

   task automatic test_reset_mid();
      logic [63:0] a; logic ok;
      send_req(64'h1006, 2'b10, 1'b0);
      mem_beat(64'h3412_0000_0000_0000, 1'b0, a, ok);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      rstn = 1'b0;
      #1;
      n_checks++; if (!ok || req_ready !== 1'b1 || mem_valid !== 1'b0 || mem_addr !== 64'h0 ||
                      rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 || rsp_err !== 1'b0)
         $display("FAIL midreset_outputs got ready=%b mv=%b ma=%h rv=%b rd=%h re=%b want reset values",
                  req_ready, mem_valid, mem_addr, rsp_valid, rsp_rdata, rsp_err); else n_pass++;
      step();
      rstn = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 64'h89AB;
      step();
      mem_rvalid = 1'b0; mem_rdata = '0;
      step();
      n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_valid !== 1'b0)
         $display("FAIL midreset_late_rvalid got rv=%b ready=%b mv=%b want 0/1/0", rsp_valid, req_ready, mem_valid); else n_pass++;
      $display("txn reset_mid aborted");
   endtask

   task automatic test_misalign_off();
      int seen0; logic got;
      seen0 = b_mem_seen;
      got = 1'b0;
      b_req_valid = 1'b1; b_req_addr = 64'h1007; b_req_size = 2'b01; b_req_su = 1'b0;
      step();
      b_req_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (b_rsp_valid) begin got = 1'b1; break; end
         step();
      end
      n_checks++; if (!got || b_rsp_err !== 1'b1 || b_rsp_rdata !== 64'h0)
         $display("FAIL nomis_err got valid=%b err=%b rdata=%h want 1/1/0", got, b_rsp_err, b_rsp_rdata); else n_pass++;
      n_checks++; if (b_mem_seen !== seen0) $display("FAIL nomis_no_mem got=%0d want=0", b_mem_seen - seen0); else n_pass++;
      b_rsp_ready = 1'b1;
      step();
      b_rsp_ready = 1'b0;
      $display("txn misalign_off addr=1007 err=%b", b_rsp_err);
   endtask

   initial begin
      req_valid = 0; req_addr = 0; req_size = 0; req_su = 0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0; rsp_ready = 0;
      b_req_valid = 0; b_req_addr = 0; b_req_size = 0; b_req_su = 0; b_rsp_ready = 0;
      rstn = 0;
      step();
      test_reset();
      test_byte_signed();
      test_half_zext();
      test_word_cross();
      test_cross_err();
      test_backpressure();
      test_reset_mid();
      test_misalign_off();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/core_ldalign.md
Name: core_ldalign

Overview:
- Parametrised load-data unit in the core memory stage. It sits between the LSU request path and the data-memory port.
- It accepts one load at a time, issues one aligned memory beat, or two when a misaligned access crosses an XLEN boundary. It merges the beats, shifts the addressed bytes down, and sign- or zero-extends them to XLEN.
- Valid/ready handshakes on all three sides. Bus errors and unsupported sizes are reported.

Parameters:
- XLEN, 64, data width; legal values 32 or 64.
- AW, 64, address width.
- MISALIGN_EN, 1, 1 = split boundary-crossing loads; 0 = flag them as errors with no memory access.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset; asynchronous, active-low
- i_req_valid  in  1  load request valid
- o_req_ready  out  1  unit idle, request can be accepted
- i_req_addr  in  AW  byte address
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 double
- i_req_su_extend  in  1  0 = sign-extend, 1 = zero-extend
- o_mem_valid  out  1  memory read beat valid
- i_mem_ready  in  1  memory accepts beat
- o_mem_addr  out  AW  beat address, aligned to XLEN/8 bytes
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  XLEN  read data
- i_mem_err  in  1  bus error, qualified by i_mem_rvalid
- o_rsp_valid  out  1  result valid
- i_rsp_ready  in  1  consumer accepts result
- o_rsp_rdata  out  XLEN  extended load result
- o_rsp_err  out  1  error flag for this result

Behaviour:
- Reset (i_rstn low, async): state IDLE. o_req_ready=1, o_mem_valid=0, o_mem_addr=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, both beat buffers cleared.
- Derived values: NB = XLEN/8; off = addr mod NB; bytes = 1 << size.
- A request crosses a boundary when off + bytes > NB.
- A request is illegal when size=11 and XLEN=32, or when it crosses a boundary and MISALIGN_EN=0.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: o_req_ready=1. On i_req_valid, latch addr/size/su_extend.
  - Illegal request: go to RESP with err=1, data=0.
  - Otherwise: go to REQ0.
- REQ0: o_mem_valid=1, o_mem_addr = addr with low log2(NB) bits cleared. Hold until i_mem_ready, then go to WAIT0.
- WAIT0: wait for i_mem_rvalid and store the beat into buf0.
  - i_mem_err=1: go to RESP with err=1, data=0. No second beat is issued.
  - Crossing request: go to REQ1.
  - Otherwise: go to RESP.
- REQ1: o_mem_addr = aligned address + NB, with wrap-around mod 2^AW. Same handshake as REQ0, then go to WAIT1.
- WAIT1: store the beat into buf1. If i_mem_err=1, err=1 and data=0. Go to RESP.
- Result computation: merged = {buf1, buf0} >> (8*off); take the low XLEN bits.
  - Zero-extend or sign-extend from bit 8*bytes-1.
  - size=11 is passed through unchanged.
  - The result is registered into o_rsp_rdata on entry to RESP.
- RESP: o_rsp_valid=1. o_rsp_rdata and o_rsp_err are held stable until i_rsp_ready, then go to IDLE. o_req_ready goes to 1 in the following cycle; there is no same-cycle bypass.
- Minimum latency:
  - Single beat: request handshake at cycle 0, o_mem_valid at cycle 1, rvalid at cycle 2 or later, o_rsp_valid 1 cycle after rvalid.
  - Crossing request adds a second REQ/WAIT pair: at least 2 more cycles.
- i_mem_rvalid is ignored in IDLE, REQ0, REQ1 and RESP. It is accepted only in the WAIT states.
- i_mem_err is ignored when i_mem_rvalid=0.
- Reset asserted mid-operation aborts the transaction immediately. Data returned after reset is ignored.
- Only one transaction is outstanding at a time. i_req_* is not sampled while busy.

Decomposition:
- Package core_ldalign_pkg holds:
  - typedef enum ldalign_state_e for the FSM states
  - typedef ld_size_e with values LD_B, LD_H, LD_W, LD_D
  - function size_bytes
- Sub-module core_ldext_unit: purely combinational, parametrised by XLEN. Inputs are the shifted XLEN data, size and su_extend; output is the extended XLEN result. It is instantiated once after the merge shifter.

Test Plan (XLEN=64, MISALIGN_EN=1 unless noted):
- Signed byte load, addr 0x1003, rdata 0x00000000_80000000 -> one beat at 0x1000; o_rsp_rdata=0xFFFFFFFF_FFFFFF80, err=0.
- Zero-extended half load, addr 0x1006, rdata 0xBEEF0000_00000000 -> o_rsp_rdata=0x00000000_0000BEEF.
- Signed word load, addr 0x1006; beat0 rdata[63:48]=0x3412; beat1 rdata[15:0]=0x89AB -> beats at 0x1000 then 0x1008; o_rsp_rdata=0xFFFFFFFF_89AB3412.
- Same crossing load with i_mem_err=1 on beat0 -> exactly one memory handshake; o_rsp_err=1, o_rsp_rdata=0.
- i_rsp_ready held low 3 cycles in RESP -> o_rsp_valid and o_rsp_rdata stable, o_req_ready=0; i_mem_ready low 2 cycles in REQ0 -> o_mem_addr stable.
- Reset pulsed in WAIT1 -> all outputs at reset values next edge; late i_mem_rvalid ignored. With MISALIGN_EN=0, crossing load at addr 0x1007 size 01 -> no o_mem_valid, o_rsp_err=1.
